// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_lsu data memory: access sizes,
// response error codes, FSM states, the error poison word and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } dmem_size_e;

    typedef enum logic [1:0] {
        ERR_OK           = 2'b00,
        ERR_MISALIGN     = 2'b01,
        ERR_RANGE        = 2'b10,
        ERR_ILLEGAL_SIZE = 2'b11
    } dmem_err_e;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } dmem_state_e;

    localparam logic [31:0] DMEM_POISON = 32'hDEADBEEF;

    // Extend a right-aligned byte (is_half = 0) or half (is_half = 1) to 32 bits.
    function automatic logic [31:0] dmem_extend(
        input logic [15:0] val,
        input logic        is_half,
        input logic        is_unsigned
    );
        logic sign;
        sign = is_unsigned ? 1'b0 : (is_half ? val[15] : val[7]);
        return is_half ? {{16{sign}}, val} : {{24{sign}}, val[7:0]};
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for dmem_lsu: byte enables, lane-replicated
// store data, extended load data and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic        i_unsigned,
    input  logic [31:0] i_rdata_raw,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_lane,
    output logic [31:0] o_rdata_ext,
    output logic        o_misalign
);

    dmem_size_e  w_size;
    logic [7:0]  w_byte [4];
    logic [15:0] w_half;

    assign w_size = dmem_size_e'(i_size);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_byte[gi] = i_rdata_raw[8*gi +: 8];
        end
    endgenerate

    assign w_half = i_addr_lo[1] ? i_rdata_raw[31:16] : i_rdata_raw[15:0];

    // Store data is replicated across lanes; the byte enable picks the live one.
    always_comb begin
        o_be         = 4'b0000;
        o_wdata_lane = i_wdata;
        o_rdata_ext  = i_rdata_raw;
        o_misalign   = 1'b0;
        case (w_size)
            SZ_B: begin
                o_be         = 4'b0001 << i_addr_lo;
                o_wdata_lane = {4{i_wdata[7:0]}};
                o_rdata_ext  = dmem_extend({8'h00, w_byte[i_addr_lo]}, 1'b0, i_unsigned);
            end
            SZ_H: begin
                o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata_lane = {2{i_wdata[15:0]}};
                o_rdata_ext  = dmem_extend(w_half, 1'b1, i_unsigned);
                o_misalign   = i_addr_lo[0];
            end
            SZ_W: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressable data memory with a valid/ready request port, one-cycle
// registered responses and a saturating error counter. Define
// DMEM_CLEAR_ON_RESET_EN to zero the whole array after every reset.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [1:0]           rsp_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e          r_state;
    dmem_state_e          w_state_next;
    logic                 r_ready;
    logic                 w_ready_next;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic [1:0]           r_rsp_err;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [31:0]          r_mem [DEPTH_WORDS];

    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_range;
    logic                 w_illegal;
    dmem_err_e            w_err;
    logic [IDX_W-1:0]     w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata_lane;
    logic [31:0]          w_rdata_raw;
    logic [31:0]          w_rdata_ext;

    logic                 w_mem_we;
    logic [IDX_W-1:0]     w_mem_idx;
    logic [3:0]           w_mem_be;
    logic [31:0]          w_mem_wdata;

`ifdef DMEM_CLEAR_ON_RESET_EN
    localparam dmem_state_e      RESET_STATE = ST_CLEAR;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DEPTH_WORDS - 1);
    logic [IDX_W-1:0] r_clr_cnt;
    logic [IDX_W-1:0] w_clr_cnt_next;
`else
    localparam dmem_state_e      RESET_STATE = ST_IDLE;
`endif

    assign w_accept    = req_valid && r_ready;
    assign w_idx       = req_addr[IDX_W+1:2];
    assign w_range     = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_illegal   = (req_size == SZ_BAD);
    assign w_rdata_raw = r_mem[w_idx];

    dmem_lane_align u_lane_align (
        .i_size       (req_size),
        .i_addr_lo    (req_addr[1:0]),
        .i_wdata      (req_wdata),
        .i_unsigned   (req_unsigned),
        .i_rdata_raw  (w_rdata_raw),
        .o_be         (w_be),
        .o_wdata_lane (w_wdata_lane),
        .o_rdata_ext  (w_rdata_ext),
        .o_misalign   (w_misalign)
    );

    always_comb begin
        w_err = ERR_OK;
        if (w_illegal) begin
            w_err = ERR_ILLEGAL_SIZE;
        end else if (w_misalign) begin
            w_err = ERR_MISALIGN;
        end else if (w_range) begin
            w_err = ERR_RANGE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RESET_STATE;
            r_ready   <= 1'b0;
`ifdef DMEM_CLEAR_ON_RESET_EN
            r_clr_cnt <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_ready   <= w_ready_next;
`ifdef DMEM_CLEAR_ON_RESET_EN
            r_clr_cnt <= w_clr_cnt_next;
`endif
        end
    end

    // The single array write port is shared between the clear sweep and stores.
    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_idx    = w_idx;
        w_mem_be     = w_be;
        w_mem_wdata  = w_wdata_lane;
`ifdef DMEM_CLEAR_ON_RESET_EN
        w_clr_cnt_next = r_clr_cnt;
`endif
        case (r_state)
`ifdef DMEM_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                w_mem_we    = 1'b1;
                w_mem_idx   = r_clr_cnt;
                w_mem_be    = 4'b1111;
                w_mem_wdata = '0;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                    w_ready_next = 1'b1;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
                w_ready_next = 1'b1;
                w_mem_we     = w_accept && req_write && (w_err == ERR_OK);
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mem_be[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= w_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_OK;
            r_err_count <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_err <= w_err;
                if (w_err != ERR_OK) begin
                    r_rsp_rdata <= DMEM_POISON;
                end else if (req_write) begin
                    r_rsp_rdata <= '0;
                end else begin
                    r_rsp_rdata <= w_rdata_ext;
                end
                if ((w_err != ERR_OK) && (r_err_count != '1)) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign req_ready = r_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_err_count;

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Parametrised, byte-addressable data memory with a valid/ready request port and registered one-cycle responses for the RISC-V core's load/store path. Implements the LB/LH/LW/LBU/LHU/SB/SH/SW access sizes with per-byte write lanes and sign or zero extension. Detects misaligned, out-of-range and illegal-size accesses and keeps a saturating error counter. Sits between the execute/LSU stage and the word-organised data array.

## Interface
- `DEPTH_WORDS`, 16: number of 32-bit words; must be ≥ 2.
- `ERR_CNT_W`, 16: width of the error counter.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts a request this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: zero-extend loads (LBU/LHU); ignored for word loads and stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load result; 0 for stores; 32'hDEADBEEF on error.
- `rsp_err` out 2: 00 OK, 01 MISALIGN, 10 RANGE, 11 ILLEGAL_SIZE.
- `err_count` out ERR_CNT_W: saturating count of errored requests.

## Operation
- A request is accepted when `req_valid && req_ready`. There is no response backpressure.
- States:
  - CLEAR: present only with the macro.
  - IDLE: `req_ready` = 1; accepts one request per cycle, back-to-back.
- Error priority is ILLEGAL_SIZE > MISALIGN > RANGE.
  - MISALIGN: half access with `addr[0]` = 1, or word access with `addr[1:0]` ≠ 0.
  - RANGE: `addr[31:2]` ≥ `DEPTH_WORDS`.
- An errored request:
  - writes nothing;
  - returns `rsp_rdata` = 32'hDEADBEEF and the error code;
  - increments `err_count`, which saturates at all-ones and does not wrap.
- Store lanes:
  - SB writes `wdata[7:0]` into lane `addr[1:0]`.
  - SH writes `wdata[15:0]` into lanes {2·addr[1]+1, 2·addr[1]}.
  - SW writes all four lanes.
  - Unselected lanes are preserved.
- Load extract:
  - Select the lane(s) by `addr[1:0]`.
  - Sign-extend from bit 7 or bit 15 unless `req_unsigned` is set.
  - Word loads return the full word.
- Stores also produce a response: `rsp_valid` = 1, `rsp_rdata` = 0, `rsp_err` = 00.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 00, `err_count` = 0.
  - State is CLEAR with the macro, IDLE without it.
- Without the macro, `req_ready` rises at the first rising edge after `reset` deasserts.
- Latency: a request accepted at edge N produces `rsp_*` valid during cycle N+1, for exactly one cycle unless another request is accepted.
- Stores commit at the accept edge. A load accepted at the next edge to the same word returns the new data; no forwarding logic is needed.
- Asserting reset mid-operation:
  - drops any pending response, and `rsp_valid` falls immediately (asynchronously);
  - leaves array contents untouched without the macro;
  - restarts the clear with the macro.
- The memory array itself is not reset.

## Configuration
- `DMEM_CLEAR_ON_RESET_EN` defined:
  - After reset the block stays in CLEAR and writes 0 to word k at the k-th edge, k = 0…DEPTH_WORDS−1.
  - `req_ready` stays 0 throughout.
  - At the edge that writes the last word, the state becomes IDLE and `req_ready` rises, i.e. `req_ready` = 1 after exactly `DEPTH_WORDS` edges.
  - The clear counter is $clog2(DEPTH_WORDS) bits wide and stops at the last word.
- Undefined: no CLEAR state and no counter; contents are whatever was loaded or previously written.

## Structure
- Package `dmem_pkg` holds:
  - the size enum (`SZ_B`, `SZ_H`, `SZ_W`, `SZ_BAD`);
  - the error-code enum;
  - `DMEM_POISON` = 32'hDEADBEEF;
  - the state enum.
- Sub-module `dmem_lane_align` is purely combinational. From size, `addr[1:0]`, `wdata` and `unsigned` it produces:
  - the 4-bit byte-enable;
  - lane-shifted write data;
  - the extended load result from the raw word;
  - the misalign flag.
- The top level holds the FSM, the array, the response register and the counter.

## Test plan
- Reset only (macro off): `req_ready` = 0 during reset and 1 one edge after release; `err_count` = 0.
- SW 0x8000_00F0 @0x4, then LB @0x4 → 0xFFFF_FFF0; LBU @0x4 → 0x0000_00F0; LH @0x6 → 0xFFFF_8000; each response one cycle after accept.
- SB 0xAA @0x9 over a word holding 0x1122_3344 at 0x8, then LW @0x8 back-to-back → 0x1122_AA44.
- Misaligned and bad requests:
  - LW @0x2 → `rsp_err` = 01, `rsp_rdata` = 0xDEADBEEF.
  - SH @0x41 (DEPTH 16) → `rsp_err` = 01, not 10; memory unchanged.
  - size 11 → `rsp_err` = 11.
  - `err_count` = 3.
- With `ERR_CNT_W` = 2, issue 5 errored requests → `err_count` holds at 3.
- Macro on, `DEPTH_WORDS` = 16:
  - `req_ready` rises after 16 edges; LW @0x3C → 0.
  - Reset pulse at clear step 7 restarts the full 16-cycle clear.
